// File: rtl/fdc_dma_fifo.sv
// Floppy-controller DMA FIFO: DEPTH x DATA_W storage with a DRQ burst FSM
// that asks for service once enough data or space is available for a burst.
module fdc_dma_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              dir,
  input  logic [CNT_W-1:0]  thresh,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  input  logic              tc,
  output logic              drq,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overrun,
  output logic              underrun,
  output logic              tc_seen
);

  localparam int               ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  eff_thr, space;
  logic              push, pop, dir_q, trigger, end_burst;
  state_t            state, state_nxt;

  // Pointers carry one extra wrap bit, so their difference is the occupancy.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign space   = DEPTH_C - count;
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push && !reset && !flush)
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
      tc_seen  <= 1'b0;
    end else begin
      if (push)          wr_ptr   <= wr_ptr + ONE;
      if (pop)           rd_ptr   <= rd_ptr + ONE;
      if (wr_en && full) overrun  <= 1'b1;
      if (rd_en && empty) underrun <= 1'b1;
      if (tc)            tc_seen  <= 1'b1;
    end
  end

  always_comb begin
    eff_thr = thresh;
    if (thresh == '0)
      eff_thr = ONE;
    else if (thresh > DEPTH_C)
      eff_thr = DEPTH_C;
  end

  // Trigger looks at the registered occupancy; the end condition also
  // catches the final transfer in flight so drq drops right after it.
  always_comb begin
    trigger   = dir ? (count >= eff_thr) : (space >= eff_thr);
    end_burst = dir ? ((count == ONE && pop) || empty)
                    : ((count == DEPTH_C - ONE && push) || full);
  end

  always_comb begin
    state_nxt = state;
    if (tc)
      state_nxt = DONE;
    else if (state == DONE)
      state_nxt = DONE;
    else if (dir != dir_q)
      state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (trigger)   state_nxt = BURST;
        BURST:   if (end_burst) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // dir_q tracks dir even through reset/flush so no spurious change is seen.
  always_ff @(posedge clk) begin
    dir_q <= dir;
    if (reset || flush) begin
      state <= IDLE;
      drq   <= 1'b0;
    end else begin
      state <= state_nxt;
      drq   <= (state_nxt == BURST);
    end
  end

endmodule

// File: tb/tb_fdc_dma_fifo.sv
// Directed bench for fdc_dma_fifo: main DEPTH=16 instance plus DEPTH=4 and
// DEPTH=256 instances sharing stimulus for the threshold clamp checks.
module tb_fdc_dma_fifo;

  logic       clk, reset, flush, dir, wr_en, rd_en, tc;
  logic [7:0] wr_data;
  logic [4:0] thresh_m;
  logic [2:0] thresh_s;
  logic [8:0] thresh_l;

  logic [7:0] rd_data_m, rd_data_s, rd_data_l;
  logic [4:0] count_m;
  logic [2:0] count_s;
  logic [8:0] count_l;
  logic drq_m, empty_m, full_m, overrun_m, underrun_m, tc_seen_m;
  logic drq_s, empty_s, full_s, overrun_s, underrun_s, tc_seen_s;
  logic drq_l, empty_l, full_l, overrun_l, underrun_l, tc_seen_l;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] q[$];

  fdc_dma_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .dir(dir), .thresh(thresh_m),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data_m),
    .tc(tc), .drq(drq_m), .count(count_m), .empty(empty_m), .full(full_m),
    .overrun(overrun_m), .underrun(underrun_m), .tc_seen(tc_seen_m)
  );

  fdc_dma_fifo #(.DATA_W(8), .DEPTH(4)) dut_s (
    .clk(clk), .reset(reset), .flush(flush), .dir(dir), .thresh(thresh_s),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data_s),
    .tc(tc), .drq(drq_s), .count(count_s), .empty(empty_s), .full(full_s),
    .overrun(overrun_s), .underrun(underrun_s), .tc_seen(tc_seen_s)
  );

  fdc_dma_fifo #(.DATA_W(8), .DEPTH(256)) dut_l (
    .clk(clk), .reset(reset), .flush(flush), .dir(dir), .thresh(thresh_l),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data_l),
    .tc(tc), .drq(drq_l), .count(count_l), .empty(empty_l), .full(full_l),
    .overrun(overrun_l), .underrun(underrun_l), .tc_seen(tc_seen_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; dir = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    tc = 1'b0; wr_data = 8'h00;
    thresh_m = 5'd4; thresh_s = 3'd4; thresh_l = 9'd4;
    step(); step();
    check("rst_count", 32'(count_m), 0);
    check("rst_empty", 32'(empty_m), 1);
    check("rst_full", 32'(full_m), 0);
    check("rst_drq", 32'(drq_m), 0);
    check("rst_flags", 32'({overrun_m, underrun_m, tc_seen_m}), 0);

    // dir=1, thresh=4: drq one cycle after count reaches 4, drops after last pop
    reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    check("rd_cnt4", 32'(count_m), 4);
    check("rd_drq_lag", 32'(drq_m), 0);
    step();
    check("rd_drq_rise", 32'(drq_m), 1);
    for (int i = 0; i < 4; i++) begin
      check("rd_order", 32'(rd_data_m), 32'(8'hA0 + 8'(i)));
      rd_en = 1'b1;
      step();
      if (i == 2) check("rd_drq_hold", 32'(drq_m), 1);
    end
    rd_en = 1'b0;
    check("rd_drq_fall", 32'(drq_m), 0);
    check("rd_empty", 32'(empty_m), 1);

    // dir=0, thresh=8: empty FIFO requests right after reset release
    reset = 1'b1; dir = 1'b0; thresh_m = 5'd8;
    step();
    check("wr_drq_in_rst", 32'(drq_m), 0);
    reset = 1'b0;
    step();
    check("wr_drq_rise", 32'(drq_m), 1);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      if (i == 14) check("wr_drq_hold", 32'(drq_m), 1);
    end
    check("wr_drq_fall", 32'(drq_m), 0);
    check("wr_full", 32'(full_m), 1);
    step();
    wr_en = 1'b0;
    check("ovr_set", 32'(overrun_m), 1);
    check("ovr_cnt", 32'(count_m), 16);

    // Fill, then concurrent push/pop across pointer wrap
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_ovr", 32'(overrun_m), 0);
    check("flush_cnt", 32'(count_m), 0);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i); q.push_back(wr_data);
      step();
    end
    wr_en = 1'b0;
    check("fill_full", 32'(full_m), 1);
    rd_en = 1'b1;
    step();
    void'(q.pop_front());
    rd_en = 1'b0;
    check("fill_cnt15", 32'(count_m), 15);
    for (int k = 0; k < 20; k++) begin
      check("wrap_order", 32'(rd_data_m), 32'(q[0]));
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h20 + 8'(k);
      step();
      void'(q.pop_front());
      q.push_back(8'h20 + 8'(k));
    end
    wr_en = 1'b0; rd_en = 1'b0;
    check("wrap_cnt", 32'(count_m), 15);
    check("wrap_no_ovr", 32'(overrun_m), 0);

    // Full with push and pop together: pop wins, push dropped, overrun set
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    q.push_back(8'h55);
    wr_data = 8'h66; rd_en = 1'b1;
    step();
    void'(q.pop_front());
    wr_en = 1'b0; rd_en = 1'b0;
    check("fullboth_cnt", 32'(count_m), 15);
    check("fullboth_ovr", 32'(overrun_m), 1);
    for (int i = 0; i < 15; i++) begin
      check("drain_order", 32'(rd_data_m), 32'(q[0]));
      rd_en = 1'b1;
      step();
      void'(q.pop_front());
    end
    rd_en = 1'b0;
    check("drain_empty", 32'(empty_m), 1);

    // Underrun, empty push+pop, tc, flush clears flags
    flush = 1'b1;
    step();
    flush = 1'b0;
    rd_en = 1'b1;
    step();
    check("unr_set", 32'(underrun_m), 1);
    check("unr_cnt", 32'(count_m), 0);
    wr_en = 1'b1; wr_data = 8'h77;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("emptyboth_cnt", 32'(count_m), 1);
    check("emptyboth_unr", 32'(underrun_m), 1);
    check("emptyboth_data", 32'(rd_data_m), 32'h77);
    tc = 1'b1;
    step();
    tc = 1'b0;
    check("tc_seen_set", 32'(tc_seen_m), 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_flags", 32'({overrun_m, underrun_m, tc_seen_m}), 0);
    check("flush_cnt2", 32'(count_m), 0);

    // Mid-burst tc locks the FSM in DONE until flush
    dir = 1'b1; thresh_m = 5'd4;
    step();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    step();
    check("tc_pre_drq", 32'(drq_m), 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    tc = 1'b1;
    step();
    tc = 1'b0;
    check("tc_drq_drop", 32'(drq_m), 0);
    check("tc_seen", 32'(tc_seen_m), 1);
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'hD0 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    step();
    check("done_hold_cnt", 32'(count_m), 6);
    check("done_hold_drq", 32'(drq_m), 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("done_flush_tc", 32'(tc_seen_m), 0);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'hE0 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    step();
    check("rearm_drq", 32'(drq_m), 1);
    dir = 1'b0;
    step();
    check("dirchg_idle", 32'(drq_m), 0);
    step();
    check("dirchg_retrig", 32'(drq_m), 1);

    // thresh=0 acts as 1 on every depth
    reset = 1'b1; dir = 1'b1;
    thresh_m = 5'd0; thresh_s = 3'd0; thresh_l = 9'd0;
    step();
    reset = 1'b0;
    step();
    check("thr0_idle", 32'({drq_s, drq_m, drq_l}), 0);
    wr_en = 1'b1; wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    check("thr0_lag", 32'({drq_s, drq_m, drq_l}), 0);
    step();
    check("thr0_drq_s", 32'(drq_s), 1);
    check("thr0_drq_m", 32'(drq_m), 1);
    check("thr0_drq_l", 32'(drq_l), 1);

    // Oversized thresh clamps to DEPTH (DEPTH=4 uses its largest code, 7)
    reset = 1'b1; dir = 1'b0;
    thresh_m = 5'd21; thresh_s = 3'd7; thresh_l = 9'd261;
    step();
    reset = 1'b0;
    step();
    check("thrbig_drq_s", 32'(drq_s), 1);
    check("thrbig_drq_m", 32'(drq_m), 1);
    check("thrbig_drq_l", 32'(drq_l), 1);
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'b1; wr_data = 8'h90 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    check("burst_drq_s", 32'(drq_s), 1);
    check("burst_cnt_l", 32'(count_l), 2);
    reset = 1'b1;
    step();
    check("rstmid_drq", 32'({drq_s, drq_m, drq_l}), 0);
    check("rstmid_empty", 32'({empty_s, empty_m, empty_l}), 32'b111);
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
